// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_pkg
// Brief    : Shared types and defaults for the two-channel input debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package fsm_pkg;

    typedef enum logic [1:0] {
        DB_ZERO  = 2'd0,
        DB_WAIT1 = 2'd1,
        DB_ONE   = 2'd2,
        DB_WAIT0 = 2'd3
    } db_state_t;

    // 10 ms settle window at a 100 MHz system clock
    localparam int DB_CYCLES_100MHZ    = 1000000;
    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Brief    : One input: synchronizer, 4-state debounce FSM, stability counter,
//            registered level and one-cycle rising-edge tick.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import fsm_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_100MHZ,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic tick
);

    localparam int                 c_CNT_W    = $clog2(DB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_in;

    db_state_t              r_state;
    db_state_t              w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic                   r_level;
    logic                   r_tick;
    logic                   w_level_nxt;
    logic                   w_tick_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign w_sync_in = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= DB_ZERO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Any return to the current level abandons the wait; re-entry reloads the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            DB_ZERO: begin
                if (w_sync_in) begin
                    w_state_nxt = DB_WAIT1;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            DB_WAIT1: begin
                if (!w_sync_in) begin
                    w_state_nxt = DB_ZERO;
                end else if (r_cnt == '0) begin
                    w_state_nxt = DB_ONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            DB_ONE: begin
                if (!w_sync_in) begin
                    w_state_nxt = DB_WAIT0;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            DB_WAIT0: begin
                if (w_sync_in) begin
                    w_state_nxt = DB_ONE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = DB_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = DB_ZERO;
            end
        endcase
    end

    // Tick only on a completed rise; a bounce back from WAIT0 is not a new press.
    always_comb begin
        w_level_nxt = (w_state_nxt == DB_ONE) || (w_state_nxt == DB_WAIT0);
        w_tick_nxt  = (r_state == DB_WAIT1) && (w_state_nxt == DB_ONE);
    end

    assign level = r_level;
    assign tick  = r_tick;

endmodule
`default_nettype wire

// File: rtl/input_debouncer_2ch.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer_2ch
// Brief    : Two independent debounce channels producing clean levels a/b and
//            rising-edge ticks for the downstream control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module input_debouncer_2ch
    import fsm_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_100MHZ,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_a_raw,
    input  logic sw_b_raw,
    output logic a,
    output logic b,
    output logic a_tick,
    output logic b_tick
);

    debounce_channel #(
        .DB_CYCLES   (DB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ch_a (
        .clk   (clk),
        .reset (reset),
        .raw   (sw_a_raw),
        .level (a),
        .tick  (a_tick)
    );

    debounce_channel #(
        .DB_CYCLES   (DB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ch_b (
        .clk   (clk),
        .reset (reset),
        .raw   (sw_b_raw),
        .level (b),
        .tick  (b_tick)
    );

endmodule
`default_nettype wire
